// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm-clock mode/alarm controller.
package alarm_pkg;

  // Controller states; the numeric value is what the mode output carries.
  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_AL_HR   = 3'd3,
    ST_AL_MIN  = 3'd4
  } alarm_state_e;

  // Bit ranges of the BCD HHMMSS fields.
  localparam int HR_HI  = 23;
  localparam int HR_LO  = 16;
  localparam int MIN_HI = 15;
  localparam int MIN_LO = 8;
  localparam int SEC_HI = 7;
  localparam int SEC_LO = 0;

  // Modulo selectors for the two-digit BCD incrementer.
  localparam logic [6:0] MOD_HR  = 7'd24;
  localparam logic [6:0] MOD_MIN = 7'd60;

  localparam int          SNOOZE_MINS       = 5;
  localparam logic [23:0] DEFAULT_ALARM_BCD = 24'h070000;

endpackage

// File: rtl/bcd2_inc_wrap.sv
// Two-digit BCD increment with wrap. i_mod selects 24 (hours) or 60
// (minutes); any value other than 24 is treated as 60. The top value
// wraps to 00 and raises o_carry. Purely combinational.
module bcd2_inc_wrap (
  input  logic [7:0] i_val,
  input  logic [6:0] i_mod,
  output logic [7:0] o_val,
  output logic       o_carry
);

  logic [7:0] w_last;

  assign w_last = (i_mod == 7'd24) ? 8'h23 : 8'h59;

  // BCD ordering matches binary ordering for valid digits, so a plain
  // compare finds the wrap point (and also folds any out-of-range value to 00).
  always_comb begin
    o_carry = 1'b0;
    if (i_val >= w_last) begin
      o_val   = 8'h00;
      o_carry = 1'b1;
    end else if (i_val[3:0] >= 4'd9) begin
      o_val = {i_val[7:4] + 4'd1, 4'd0};
    end else begin
      o_val = {i_val[7:4], i_val[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Mode and alarm controller: walks the user through time-set and
// alarm-set modes, loads the edited time into the clock counter,
// compares the stored alarm against running time and drives ring.
// Optional snooze is built only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter logic [23:0] DEFAULT_ALARM = DEFAULT_ALARM_BCD
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_snooze,
  input  logic        alarm_en,
  input  logic [23:0] time_bcd,
  output logic        load,
  output logic [23:0] load_bcd,
  output logic [23:0] alarm_bcd,
  output logic        ring,
  output logic [2:0]  mode,
  output logic [23:0] disp_bcd
);

  localparam logic [2:0] S_RUN     = ST_RUN;
  localparam logic [2:0] S_SET_HR  = ST_SET_HR;
  localparam logic [2:0] S_SET_MIN = ST_SET_MIN;
  localparam logic [2:0] S_AL_HR   = ST_AL_HR;
  localparam logic [2:0] S_AL_MIN  = ST_AL_MIN;

  logic [2:0]  r_state;
  logic [23:0] r_edit;
  logic        r_load;
  logic [23:0] r_load_bcd;
  logic [23:0] r_alarm;
  logic [23:0] r_disp;
  logic        r_ring;
  logic        r_hit_q;
  logic [15:0] r_match_hm;

  logic [7:0]  w_hr_inc;
  logic [7:0]  w_min_inc;
  logic        w_unused_hr_c;
  logic        w_unused_min_c;
  logic        w_al_hit;
  logic        w_snz_hit;
  logic        w_snz_press;
  logic        w_hit;
  logic        w_ring_set;
  logic        w_ring_clr;

  bcd2_inc_wrap u_hr_inc (
    .i_val   (r_edit[HR_HI:HR_LO]),
    .i_mod   (MOD_HR),
    .o_val   (w_hr_inc),
    .o_carry (w_unused_hr_c)
  );

  // Minute editing never carries into hours.
  bcd2_inc_wrap u_min_inc (
    .i_val   (r_edit[MIN_HI:MIN_LO]),
    .i_mod   (MOD_MIN),
    .o_val   (w_min_inc),
    .o_carry (w_unused_min_c)
  );

`ifdef ALARM_SNOOZE_EN
  logic        r_snz_vld;
  logic [15:0] r_snz_hm;
  logic [7:0]  w_snz_min [0:SNOOZE_MINS];
  logic [SNOOZE_MINS-1:0] w_snz_c;
  logic [7:0]  w_snz_hr_inc;
  logic        w_unused_snz_hr_c;
  logic [15:0] w_snz_target;

  // Matched minute plus SNOOZE_MINS as a chain of single increments; at
  // most one link can wrap, and that wrap bumps the hour (23 wraps to 00).
  assign w_snz_min[0] = r_match_hm[7:0];
  for (genvar g = 0; g < SNOOZE_MINS; g++) begin : g_snz
    bcd2_inc_wrap u_snz_min (
      .i_val   (w_snz_min[g]),
      .i_mod   (MOD_MIN),
      .o_val   (w_snz_min[g+1]),
      .o_carry (w_snz_c[g])
    );
  end

  bcd2_inc_wrap u_snz_hr (
    .i_val   (r_match_hm[15:8]),
    .i_mod   (MOD_HR),
    .o_val   (w_snz_hr_inc),
    .o_carry (w_unused_snz_hr_c)
  );

  assign w_snz_target = {((|w_snz_c) ? w_snz_hr_inc : r_match_hm[15:8]),
                         w_snz_min[SNOOZE_MINS]};
  assign w_snz_hit    = r_snz_vld && (time_bcd[HR_HI:MIN_LO] == r_snz_hm);
  assign w_snz_press  = btn_snooze && r_ring;

  // Snooze target: armed by a snooze press while ringing, dropped on mode/disarm.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_snz_vld <= 1'b0;
      r_snz_hm  <= '0;
    end else if (btn_mode || !alarm_en) begin
      r_snz_vld <= 1'b0;
    end else if (w_snz_press) begin
      r_snz_vld <= 1'b1;
      r_snz_hm  <= w_snz_target;
    end
  end
`else
  logic w_unused_snooze;

  assign w_unused_snooze = btn_snooze;
  assign w_snz_hit       = 1'b0;
  assign w_snz_press     = 1'b0;
`endif

  // A hit is the top of a matching minute; ring only on its first cycle so
  // a dismissed alarm does not re-trigger for the rest of that second.
  assign w_al_hit   = (time_bcd[HR_HI:MIN_LO] == r_alarm[HR_HI:MIN_LO]);
  assign w_hit      = alarm_en && (time_bcd[SEC_HI:SEC_LO] == 8'h00) &&
                      (w_al_hit || w_snz_hit);
  assign w_ring_set = (r_state == S_RUN) && w_hit && !r_hit_q;
  assign w_ring_clr = btn_mode || !alarm_en || w_snz_press ||
                      (r_ring && (time_bcd[HR_HI:MIN_LO] != r_match_hm));

  // Mode sequencing, clock load pulse and alarm write-back.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_load     <= 1'b0;
      r_load_bcd <= '0;
      r_alarm    <= DEFAULT_ALARM;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        S_RUN:     if (btn_mode && !r_ring) r_state <= S_SET_HR;
        S_SET_HR:  if (btn_mode) r_state <= S_SET_MIN;
        S_SET_MIN: if (btn_mode) begin
                     r_state    <= S_AL_HR;
                     r_load     <= 1'b1;
                     r_load_bcd <= r_edit;
                   end
        S_AL_HR:   if (btn_mode) r_state <= S_AL_MIN;
        S_AL_MIN:  if (btn_mode) begin
                     r_state <= S_RUN;
                     r_alarm <= r_edit;
                   end
        default:   r_state <= S_RUN;
      endcase
    end
  end

  // Edit register: seeded on mode entry, stepped by inc; mode beats inc.
  always_ff @(posedge CLK100MHZ) begin
    case (r_state)
      S_RUN: if (btn_mode && !r_ring) r_edit <= {time_bcd[HR_HI:MIN_LO], 8'h00};
      S_SET_HR, S_AL_HR: if (!btn_mode && btn_inc) r_edit[HR_HI:HR_LO] <= w_hr_inc;
      S_SET_MIN: begin
        if (btn_mode)     r_edit <= r_alarm;
        else if (btn_inc) r_edit[MIN_HI:MIN_LO] <= w_min_inc;
      end
      S_AL_MIN: if (!btn_mode && btn_inc) r_edit[MIN_HI:MIN_LO] <= w_min_inc;
      default: ;
    endcase
  end

  // Display follows running time in RUN and the edit value elsewhere.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) r_disp <= '0;
    else       r_disp <= (r_state == S_RUN) ? time_bcd : r_edit;
  end

  // Ring output, remembering which HH:MM set it for auto-off and snooze.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_ring     <= 1'b0;
      r_hit_q    <= 1'b0;
      r_match_hm <= '0;
    end else begin
      r_hit_q <= w_hit;
      if (w_ring_clr) begin
        r_ring <= 1'b0;
      end else if (w_ring_set) begin
        r_ring     <= 1'b1;
        r_match_hm <= time_bcd[HR_HI:MIN_LO];
      end
    end
  end

  assign load      = r_load;
  assign load_bcd  = r_load_bcd;
  assign alarm_bcd = r_alarm;
  assign ring      = r_ring;
  assign mode      = r_state;
  assign disp_bcd  = r_disp;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: reset values, time/alarm editing with
// wrap, load pulse, ring set/clear paths, reset mid-edit and snooze
// (snooze expectations depend on ALARM_SNOOZE_EN).
module tb_alarm_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_mode;
  logic        btn_inc;
  logic        btn_snooze;
  logic        alarm_en;
  logic [23:0] time_bcd;
  logic        load;
  logic [23:0] load_bcd;
  logic [23:0] alarm_bcd;
  logic        ring;
  logic [2:0]  mode;
  logic [23:0] disp_bcd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alarm_ctrl dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_snooze (btn_snooze),
    .alarm_en   (alarm_en),
    .time_bcd   (time_bcd),
    .load       (load),
    .load_bcd   (load_bcd),
    .alarm_bcd  (alarm_bcd),
    .ring       (ring),
    .mode       (mode),
    .disp_bcd   (disp_bcd)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press_mode;
    btn_mode = 1'b1;
    tick;
    btn_mode = 1'b0;
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1;
      tick;
      btn_inc = 1'b0;
      tick;
    end
  endtask

  initial begin
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0;
    alarm_en = 1'b0; time_bcd = 24'h000000;
    tick; tick;
    chk("rst_mode", mode, 0);
    chk("rst_load", load, 0);
    chk("rst_load_bcd", load_bcd, 24'h000000);
    chk("rst_alarm", alarm_bcd, 24'h070000);
    chk("rst_ring", ring, 0);
    chk("rst_disp", disp_bcd, 24'h000000);
    reset = 1'b0;

    // Set time 12:30:15 -> 15:32, then into alarm editing
    time_bcd = 24'h123015;
    tick;
    chk("run_disp", disp_bcd, 24'h123015);
    press_mode;
    chk("to_set_hr", mode, 1);
    press_inc(3);
    chk("hr_edit", disp_bcd, 24'h153000);
    press_mode;
    chk("to_set_min", mode, 2);
    press_inc(2);
    chk("min_edit", disp_bcd, 24'h153200);
    press_mode;
    chk("load_pulse", load, 1);
    chk("load_bcd", load_bcd, 24'h153200);
    chk("to_al_hr", mode, 3);
    tick;
    chk("load_drop", load, 0);
    chk("al_edit_seed", disp_bcd, 24'h070000);

    // Hour wrap 23 -> 00, minute wrap 59 -> 00 without hour carry
    press_inc(16);
    chk("hr_23", disp_bcd, 24'h230000);
    press_inc(1);
    chk("hr_wrap", disp_bcd, 24'h000000);
    press_mode;
    chk("to_al_min", mode, 4);
    press_inc(59);
    chk("min_59", disp_bcd, 24'h005900);
    press_inc(1);
    chk("min_wrap", disp_bcd, 24'h000000);

    // Reset in AL_MIN discards the edit, no load
    reset = 1'b1;
    tick;
    chk("rstedit_mode", mode, 0);
    chk("rstedit_alarm", alarm_bcd, 24'h070000);
    chk("rstedit_load", load, 0);
    reset = 1'b0;
    tick;
    chk("rstedit_load2", load, 0);
    chk("rstedit_mode2", mode, 0);

    // Alarm at 07:00 rings, auto-off at 07:01
    alarm_en = 1'b1;
    time_bcd = 24'h065959;
    tick; tick;
    chk("pre_match", ring, 0);
    time_bcd = 24'h070000;
    tick;
    chk("ring_rise", ring, 1);
    tick;
    chk("ring_hold", ring, 1);
    time_bcd = 24'h070030;
    tick;
    chk("ring_mid_min", ring, 1);
    time_bcd = 24'h070100;
    tick;
    chk("ring_auto_off", ring, 0);

    // Dismiss with mode stays in RUN; next mode enters SET_HR
    time_bcd = 24'h065959;
    tick;
    time_bcd = 24'h070000;
    tick;
    chk("ring_rise2", ring, 1);
    press_mode;
    chk("dismiss_ring", ring, 0);
    chk("dismiss_mode", mode, 0);
    tick;
    chk("no_retrigger", ring, 0);
    press_mode;
    chk("after_dismiss", mode, 1);
    tick;
    chk("seed_secs0", disp_bcd, 24'h070000);
    press_mode;
    press_mode;
    chk("load2", load, 1);
    chk("load_bcd2", load_bcd, 24'h070000);
    press_mode;
    press_mode;
    chk("back_run", mode, 0);
    chk("alarm_kept", alarm_bcd, 24'h070000);

    // Disarm clears ring
    time_bcd = 24'h065959;
    tick;
    time_bcd = 24'h070000;
    tick;
    chk("ring_rise3", ring, 1);
    alarm_en = 1'b0;
    tick;
    chk("disarm_clear", ring, 0);
    time_bcd = 24'h080000;
    tick;
    alarm_en = 1'b1;
    tick;
    chk("no_ring_0800", ring, 0);

    // Mode and inc together: mode wins, hour unchanged
    press_mode;
    chk("set_hr3", mode, 1);
    btn_mode = 1'b1; btn_inc = 1'b1;
    tick;
    btn_mode = 1'b0; btn_inc = 1'b0;
    chk("mode_wins", mode, 2);
    tick;
    chk("inc_dropped", disp_bcd, 24'h080000);
    press_mode;
    chk("load3_bcd", load_bcd, 24'h080000);
    press_inc(16);
    press_mode;
    press_inc(57);
    chk("al_2357_edit", disp_bcd, 24'h235700);
    press_mode;
    chk("run_again", mode, 0);
    chk("alarm_2357", alarm_bcd, 24'h235700);

    // Ring at 23:57, then snooze
    time_bcd = 24'h235659;
    tick;
    time_bcd = 24'h235700;
    tick;
    chk("ring_2357", ring, 1);
    btn_snooze = 1'b1;
    tick;
    btn_snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
    chk("snooze_clear", ring, 0);
    time_bcd = 24'h235800;
    tick;
    time_bcd = 24'h000159;
    tick;
    chk("snooze_wait", ring, 0);
    time_bcd = 24'h000200;
    tick;
    chk("snooze_ring", ring, 1);
    press_mode;
    chk("snooze_dismiss", ring, 0);
`else
    chk("snooze_ignored", ring, 1);
    time_bcd = 24'h235800;
    tick;
    chk("auto_off_2358", ring, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Mode and alarm controller for the alarm-clock design. It sequences the user through time-set and alarm-set modes and loads new time into the `clock` counter. It holds the alarm time, compares it against the running BCD time and drives the ring output, with optional snooze. It sits between the debounced button inputs and the `clock` / display path.

## Interface

- `DEFAULT_ALARM`, 24'h070000, alarm time after reset (BCD HHMMSS).
- `CLK100MHZ`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn_mode`  in  1  single-cycle pulse, debounced: advance mode / dismiss ring.
- `btn_inc`  in  1  single-cycle pulse: increment the field being edited.
- `btn_snooze`  in  1  single-cycle pulse: snooze while ringing.
- `alarm_en`  in  1  level: alarm armed.
- `time_bcd`  in  24  running time from `clock`, as [23:20] Ht, [19:16] Hu, [15:12] Mt, [11:8] Mu, [7:4] St, [3:0] Su.
- `load`  out  1  one-cycle pulse; `clock` loads `load_bcd`.
- `load_bcd`  out  24  time to load; seconds are always 00.
- `alarm_bcd`  out  24  stored alarm; seconds are always 00.
- `ring`  out  1  alarm sounding.
- `mode`  out  3  current state encoding.
- `disp_bcd`  out  24  value to display.

## Operation

- States and `mode` encoding: RUN=0, SET_HR=1, SET_MIN=2, AL_HR=3, AL_MIN=4.
- RUN, `btn_mode`: if `ring`=1, clear ring and snooze only, and stay in RUN. Otherwise copy `time_bcd` into the edit register with seconds forced to 00, then go to SET_HR.
- SET_HR, `btn_inc`: hours step 00→23, wrapping to 00. `btn_mode`: go to SET_MIN.
- SET_MIN, `btn_inc`: minutes step 00→59, wrapping to 00. `btn_mode`: drive `load`=1 and `load_bcd`=edit, copy `alarm_bcd` into edit, then go to AL_HR.
- AL_HR and AL_MIN: the same editing rules apply. `btn_mode` in AL_MIN writes edit to `alarm_bcd` and returns to RUN.
- `btn_mode` and `btn_inc` in the same cycle: mode wins and the increment is dropped.
- `disp_bcd` shows `time_bcd` in RUN and the edit register in every other state.
- Ring set: state is RUN, `alarm_en`=1, `time_bcd[23:8]`==`alarm_bcd[23:8]`, and `time_bcd[7:0]`==8'h00.
- Ring clear:
  - `btn_mode`;
  - `alarm_en`=0;
  - `time_bcd[23:8]` no longer equal to the matched HH:MM (a 1-minute auto-off).
- A match that occurs while not in RUN is lost; there is no catch-up.
- All increments use BCD arithmetic. No field ever holds a non-BCD digit or an out-of-range value.

## Timing

- Reset values:
  - `mode`=RUN;
  - `load`=0;
  - `load_bcd`=0;
  - `alarm_bcd`=`DEFAULT_ALARM`;
  - `ring`=0;
  - `disp_bcd`=0;
  - snooze target invalid.
- All outputs are registered.
- Button sampled at edge N: state and field updates are visible at N+1.
- `load` is high for exactly the cycle after the SET_MIN `btn_mode` sample.
- `ring` rises one cycle after the match is sampled and falls one cycle after a clear condition is sampled.
- `disp_bcd` lags its source by one cycle.
- Reset mid-edit returns to RUN, discards the edit and produces no `load` pulse.

## Configuration

- Macro `ALARM_SNOOZE_EN`, when defined:
  - `btn_snooze` while `ring`=1 clears ring and sets the snooze target to the matched HH:MM + 5 minutes.
  - The addition is BCD with carry into hours and 23:5x wrapping to 00:0x.
  - A snooze-target match, using the same rules as the alarm match, sets ring again.
  - `btn_mode` or `alarm_en`=0 invalidates the target.
  - A new snooze replaces the old target.
- Macro not defined: the `btn_snooze` port is still present but ignored, and no snooze logic is built.

## Structure

- Package `alarm_pkg` holds:
  - the state enum;
  - BCD field bit-range constants;
  - `SNOOZE_MINS`=5;
  - the default alarm constant.
- Sub-module `bcd2_inc_wrap`: two-digit BCD increment with a modulo input (24 or 60) and a carry-out. It is instantiated for the hour and minute editors and for the snooze adder.

## Test plan

- Reset, then press mode, 3× inc, mode, 2× inc, then mode starting from `time_bcd`=12:30:15 → `load` pulses once with `load_bcd`=24'h153200, and `mode`=AL_HR.
- In SET_HR starting from 23, press inc → 00. In SET_MIN starting from 59, press inc → 00, with no carry into hours.
- Alarm 07:00, `alarm_en`=1, `time_bcd` steps 06:59:59→07:00:00 → `ring` high the next cycle. At 07:01:00 → `ring` low.
- Ringing, press `btn_mode` → `ring` low, `mode` still RUN. Then press `btn_mode` again → SET_HR.
- With `ALARM_SNOOZE_EN` and the alarm at 23:57: snooze while ringing → `ring` low, and it rings again at 00:02:00.
- Reset asserted in AL_MIN → `mode`=0, `alarm_bcd`=24'h070000, and no `load` pulse.
